// File: rtl/rv32_muldiv_pkg.sv
// Shared state encoding, funct3 codes and special-result constants for the
// M-extension sequencer.
package rv32_muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } muldiv_state_e;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/rv32_muldiv_special.sv
// Detects div/rem operand pairs whose result is fixed by the ISA
// (divide-by-zero, signed overflow) so they never reach the iterative unit.
module rv32_muldiv_special
  import rv32_muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        is_special_o,
  output logic [31:0] special_result_o
);

  logic div0, ovf;

  assign div0 = (b_i == 32'd0);
  assign ovf  = (a_i == INT_MIN) && (b_i == DIV0_QUOTIENT);

  always_comb begin
    is_special_o     = 1'b0;
    special_result_o = '0;
    case (op_i)
      MULDIV_DIV: begin
        if (div0)     begin is_special_o = 1'b1; special_result_o = DIV0_QUOTIENT; end
        else if (ovf) begin is_special_o = 1'b1; special_result_o = INT_MIN; end
      end
      MULDIV_DIVU: if (div0) begin is_special_o = 1'b1; special_result_o = DIV0_QUOTIENT; end
      MULDIV_REM: begin
        if (div0)     begin is_special_o = 1'b1; special_result_o = a_i; end
        else if (ovf) begin is_special_o = 1'b1; special_result_o = '0; end
      end
      MULDIV_REMU: if (div0) begin is_special_o = 1'b1; special_result_o = a_i; end
      MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_muldiv_ctrl.sv
// Execute-stage sequencer for the multi-cycle mul/div unit: launch, stall, capture.
// Optional result reuse of the last completed op under RV32_MULDIV_CACHE_EN.
module rv32_muldiv_ctrl
  import rv32_muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_e_i,
  input  logic [2:0]  op_e_i,
  input  logic [31:0] rs1_e_i,
  input  logic [31:0] rs2_e_i,
  input  logic        flush_e_i,
  input  logic        unit_done_i,
  input  logic [31:0] unit_result_i,
  output logic        unit_start_o,
  output logic        unit_kill_o,
  output logic [2:0]  unit_op_o,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  output logic        stall_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic        timeout_o
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic             tmo_q, tmo_d;
  logic             accept, is_special, hit;
  logic [31:0]      special_result, hit_result;

  assign accept = valid_e_i && !flush_e_i;

  rv32_muldiv_special u_special (
    .op_i             (op_e_i),
    .a_i              (rs1_e_i),
    .b_i              (rs2_e_i),
    .is_special_o     (is_special),
    .special_result_o (special_result)
  );

`ifdef RV32_MULDIV_CACHE_EN
  logic        c_vld_q, c_wr;
  logic [2:0]  c_op_q;
  logic [31:0] c_a_q, c_b_q, c_res_q;

  assign hit        = c_vld_q && (c_op_q == op_e_i) && (c_a_q == rs1_e_i) && (c_b_q == rs2_e_i);
  assign hit_result = c_res_q;
  // Only genuine completions are remembered; timeouts and flushed ops are not.
  assign c_wr = ((state_q == ST_IDLE) && accept && (is_special || hit)) ||
                ((state_q == ST_WAIT) && !flush_e_i && unit_done_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      c_vld_q <= 1'b0;
      c_op_q  <= '0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_res_q <= '0;
    end else if (c_wr) begin
      c_vld_q <= 1'b1;
      c_op_q  <= op_d;
      c_a_q   <= a_d;
      c_b_q   <= b_d;
      c_res_q <= res_d;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    tmo_d          = tmo_q;
    unit_start_o   = 1'b0;
    unit_kill_o    = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          op_d    = op_e_i;
          a_d     = rs1_e_i;
          b_d     = rs2_e_i;
          if (is_special) begin
            res_d   = special_result;
            state_d = ST_DONE;
          end else if (hit) begin
            res_d   = hit_result;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        if (flush_e_i) begin
          unit_kill_o = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          unit_start_o = 1'b1;
          stall_o      = 1'b1;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Priority: flush, then done, then timeout.
        if (flush_e_i) begin
          unit_kill_o = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (unit_done_i) begin
            res_d   = unit_result_i;
            state_d = ST_DONE;
          end else if (cnt_d == TMO_LIMIT) begin
            unit_kill_o = 1'b1;
            res_d       = '0;
            tmo_d       = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        result_valid_o = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  assign unit_op_o = op_q;
  assign unit_a_o  = a_q;
  assign unit_b_o  = b_q;
  assign result_o  = res_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_rv32_muldiv_ctrl.sv
// Randomized bench for rv32_muldiv_ctrl with a fake iterative unit and an
// ISA-level result/latency model; cache checks follow RV32_MULDIV_CACHE_EN.
module tb_rv32_muldiv_ctrl;

  localparam int TMO = 40;
`ifdef RV32_MULDIV_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_e_i, flush_e_i, unit_done_i;
  logic [2:0]  op_e_i;
  logic [31:0] rs1_e_i, rs2_e_i, unit_result_i;
  logic        unit_start_o, unit_kill_o, stall_o, result_valid_o, timeout_o;
  logic [2:0]  unit_op_o;
  logic [31:0] unit_a_o, unit_b_o, result_o;

  int n_vec = 0;
  int n_err = 0;

  // reference state: sticky timeout and last completed op
  bit          exp_tmo = 1'b0;
  bit          c_vld = 1'b0;
  logic [2:0]  c_op;
  logic [31:0] c_a, c_b, c_res;

  rv32_muldiv_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_e_i(valid_e_i), .op_e_i(op_e_i),
    .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i), .flush_e_i(flush_e_i),
    .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .unit_start_o(unit_start_o), .unit_kill_o(unit_kill_o), .unit_op_o(unit_op_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o), .stall_o(stall_o),
    .result_valid_o(result_valid_o), .result_o(result_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_spec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // dly: cycles from start pulse to unit done (<0 never).
  // fl: flush cycle relative to launch (0 = LAUNCH, k = k-th WAIT cycle), <0 none.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int dly, input int fl);
    logic [31:0] exp_res, rv_val;
    bit          fast, tmo, act;
    int          d, exp_stall, exp_start, exp_kill, exp_rv, exp_rv_cyc;
    int          stall_n, start_n, kill_n, rv_n, rv_cyc, start_cyc, last;
    exp_res = ref_mdu(op, a, b);
    fast = is_spec(op, a, b) || (CACHE_EN && c_vld && c_op == op && c_a == a && c_b == b);
    d = fast ? -1 : dly;
    tmo = 1'b0; exp_rv_cyc = 0;
    if (fast) begin
      exp_stall = 1; exp_start = 0; exp_kill = 0; exp_rv = 1; exp_rv_cyc = 1;
    end else if (fl >= 0) begin
      exp_stall = fl + 1; exp_start = (fl == 0) ? 0 : 1; exp_kill = 1; exp_rv = 0;
    end else if (d >= 1 && d <= TMO) begin
      exp_stall = d + 2; exp_start = 1; exp_kill = 0; exp_rv = 1; exp_rv_cyc = d + 2;
    end else begin
      tmo = 1'b1; exp_res = 0;
      exp_stall = TMO + 2; exp_start = 1; exp_kill = 1; exp_rv = 1; exp_rv_cyc = TMO + 2;
    end
    stall_n = 0; start_n = 0; kill_n = 0; rv_n = 0; rv_cyc = -1; start_cyc = -1;
    rv_val = 0; act = 1'b1; last = 200;
    for (int c = 0; c < last; c++) begin
      @(negedge clk_i);
      valid_e_i     = act;
      op_e_i        = act ? op : 3'($urandom());
      rs1_e_i       = act ? a : $urandom();
      rs2_e_i       = act ? b : $urandom();
      flush_e_i     = act && (fl >= 0) && (c == fl + 1);
      unit_done_i   = (d >= 0) && (c == d + 1);
      unit_result_i = unit_done_i ? ref_mdu(op, a, b) : $urandom();
      #1;
      stall_n += int'(stall_o);
      kill_n  += int'(unit_kill_o);
      if (unit_start_o) begin
        start_n++; start_cyc = c;
        chk("launch_op", 32'(unit_op_o), 32'(op));
        chk("launch_a", unit_a_o, a);
        chk("launch_b", unit_b_o, b);
      end
      if (result_valid_o) begin
        rv_n++; rv_cyc = c; rv_val = result_o;
      end
      if (act && (result_valid_o || flush_e_i)) begin
        act = 1'b0;
        last = (c + 3 > d + 4) ? c + 3 : d + 4;
      end
    end
    chk("cycle_budget", 32'(act), 32'd0);
    chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
    chk("start_pulses", 32'(start_n), 32'(exp_start));
    if (exp_start == 1) chk("start_cycle", 32'(start_cyc), 32'd1);
    chk("kill_pulses", 32'(kill_n), 32'(exp_kill));
    chk("result_valids", 32'(rv_n), 32'(exp_rv));
    if (exp_rv == 1) begin
      chk("result_cycle", 32'(rv_cyc), 32'(exp_rv_cyc));
      chk("result", rv_val, exp_res);
    end
    if (tmo) exp_tmo = 1'b1;
    chk("timeout_flag", 32'(timeout_o), 32'(exp_tmo));
    if (exp_rv == 1 && !tmo) begin
      c_vld = 1'b1; c_op = op; c_a = a; c_b = b; c_res = exp_res;
    end
  endtask

  task automatic idle_inputs();
    valid_e_i = 0; flush_e_i = 0; unit_done_i = 0;
    op_e_i = 0; rs1_e_i = 0; rs2_e_i = 0; unit_result_i = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_start"}, 32'(unit_start_o), 32'd0);
    chk({tag, "_kill"}, 32'(unit_kill_o), 32'd0);
    chk({tag, "_rvalid"}, 32'(result_valid_o), 32'd0);
    chk({tag, "_result"}, result_o, 32'd0);
    chk({tag, "_a"}, unit_a_o, 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
  endtask

  initial begin
    logic [2:0]  op, lop;
    logic [31:0] a, b, la, lb;
    int          r, d, fl, lim;
    rst_n_i = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    #1 check_quiet("reset");
    rst_n_i = 1'b1;

    // directed cases
    run_op(3'd5, 32'd100, 32'd7, 33, -1);
    run_op(3'd5, 32'd100, 32'd7, 33, -1);
    run_op(3'd4, 32'd5, 32'd0, 4, -1);
    run_op(3'd6, 32'd5, 32'd0, 4, -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4, -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4, -1);
    run_op(3'd0, 32'd3, 32'd4, 6, 2);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1);
    run_op(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, TMO, -1);
    run_op(3'd7, 32'd77, 32'd10, 0, -1);
    run_op(3'd0, 32'd9, 32'd9, -1, -1);

    // reset mid-WAIT: no kill, everything back to zero including the sticky flag
    @(negedge clk_i);
    valid_e_i = 1; op_e_i = 3'd0; rs1_e_i = 32'd6; rs2_e_i = 32'd7;
    repeat (3) @(negedge clk_i);
    #1 chk("mid_stall", 32'(stall_o), 32'd1);
    rst_n_i = 1'b0; valid_e_i = 0;
    #1 check_quiet("mid_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle_inputs();
    exp_tmo = 1'b0; c_vld = 1'b0;

    // randomized traffic
    lop = 3'd5; la = 32'd100; lb = 32'd7;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      op = 3'($urandom()); a = $urandom(); b = $urandom();
      if (r == 0) b = 0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      else if (r == 3) begin op = lop; a = la; b = lb; end
      r = int'($urandom_range(0, 19));
      if (r == 0) d = -1;
      else if (r == 1) d = 0;
      else if (r == 2) d = TMO;
      else d = int'($urandom_range(1, 12));
      if ($urandom_range(0, 5) == 0) begin
        lim = (d >= 1 && d <= TMO - 1) ? d : TMO - 1;
        fl = int'($urandom_range(0, lim));
      end else fl = -1;
      run_op(op, a, b, d, fl);
      lop = op; la = a; lb = b;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_muldiv_ctrl.md
Name: rv32_muldiv_ctrl

Overview:
- Sequences the multi-cycle M-extension unit (rv32_mul_div) from the Execute stage.
- Accepts an M-op in E and launches the unit with a start pulse, stalling F/D/E until the unit reports done.
- Presents the captured result to the E/M boundary, resolving divide-by-zero and signed-overflow cases without the unit.
- The hazard unit ORs stall_o into stall_f/stall_d and also uses it to hold E.

Parameters:
- TIMEOUT_CYCLES, 40, maximum cycles in WAIT before a timeout is declared.
- CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  reset; asynchronous, active-low
- valid_e_i  in  1  M-extension instruction present in E
- op_e_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_e_i  in  32  forwarded operand A
- rs2_e_i  in  32  forwarded operand B
- flush_e_i  in  1  squash the instruction in E
- unit_done_i  in  1  one-cycle completion pulse from the unit
- unit_result_i  in  32  unit result, valid with unit_done_i
- unit_start_o  out  1  one-cycle launch pulse
- unit_kill_o  out  1  one-cycle abort pulse to the unit
- unit_op_o  out  3  registered op
- unit_a_o  out  32  registered operand A
- unit_b_o  out  32  registered operand B
- stall_o  out  1  hold F/D/E
- result_valid_o  out  1  result_o valid this cycle
- result_o  out  32  M-op result for the E/M register
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; counter 0; all outputs 0.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - Accept when valid_e_i=1 and flush_e_i=0.
  - stall_o=1 combinationally in the accept cycle.
  - Register op and operands into unit_op_o/unit_a_o/unit_b_o.
  - Special case on a div/rem op: go to DONE with the special result registered, no unit activity.
  - Otherwise go to LAUNCH.
- LAUNCH: unit_start_o=1 for exactly one cycle; stall_o=1; counter cleared; go to WAIT.
- WAIT:
  - stall_o=1; counter increments each cycle.
  - On unit_done_i: register unit_result_i, go to DONE.
  - A done pulse arriving in LAUNCH is ignored.
- DONE:
  - result_valid_o=1 and stall_o=0 for exactly one cycle; the instruction advances into M.
  - Next state is IDLE; no re-accept occurs in DONE.
- Latency:
  - Special case: 1 stall cycle, result in cycle 2.
  - Normal: done arriving N cycles after start gives N+2 stall cycles.
- Special results:
  - DIV/DIVU with b=0: 0xFFFFFFFF.
  - REM/REMU with b=0: a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: 0x80000000.
  - REM with the same operands: 0.
- Flush in LAUNCH or WAIT:
  - unit_kill_o=1 for one cycle, unit_start_o suppressed, go to IDLE, stall_o=0.
  - A later unit_done_i is ignored while in IDLE.
- Flush in DONE is ignored; the hazard unit squashes the E/M register.
- Timeout:
  - When the counter reaches TIMEOUT_CYCLES in WAIT: unit_kill_o pulse, result 0, go to DONE, timeout_o set.
  - timeout_o clears only on reset.
- Simultaneous done and flush in WAIT: flush wins.
- Simultaneous done and timeout in the same cycle: done wins.
- Reset mid-operation: immediate return to IDLE; no kill pulse is emitted.

Optional Feature:
- Macro: RV32_MULDIV_CACHE_EN.
- When defined:
  - Holds the last completed (op, a, b, result), with a valid bit cleared at reset.
  - An accept matching all three fields takes the special-case path to DONE with the cached result.
  - A timeout result is not cached.
- When undefined: no cache storage; every non-special op launches the unit.

Decomposition:
- Package rv32_muldiv_pkg holds:
  - the state enum;
  - funct3 localparams MULDIV_MUL..MULDIV_REMU;
  - constants DIV0_QUOTIENT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Sub-module rv32_muldiv_special: combinational detector taking op, a and b, producing is_special and special_result.

Test Plan:
- DIVU 100/7, done after 33 cycles → start pulse in cycle 1; stall_o high 35 cycles; result_valid_o with 14.
- DIV 5/0 → no unit_start_o; 1 stall cycle; result 0xFFFFFFFF. REM 5/0 → result 5.
- DIV 0x80000000/0xFFFFFFFF → result 0x80000000. REM with same operands → result 0.
- MUL 3×4 with flush_e_i in WAIT cycle 2 → unit_kill_o pulse; stall_o low next cycle; later done ignored; no result_valid_o.
- Unit never returns done → timeout after 40 WAIT cycles; result 0; timeout_o stays 1.
- RV32_MULDIV_CACHE_EN: DIVU 100/7 twice back-to-back → second completes in 1 stall cycle with 14 and no start pulse.
